// File: rtl/mem_axi_counter_pkg.sv
// rtl/mem_axi_counter_pkg.sv - shared types and next-value function for the AXI counter bank
//
// Purpose: lane result type plus the pure next-value computation used by
// every counter lane. Values are carried in a fixed CNT_MAXW-bit word so one
// function serves every lane width. Lanes zero-extend their inputs and keep
// only the low C_WIDTH bits of the result.
// Ports: none (package).

package mem_axi_counter_pkg;

  localparam int unsigned CNT_MAXW = 32;

  typedef logic [CNT_MAXW-1:0] cnt_word_t;

  typedef struct packed {
    cnt_word_t count;
    logic      ovf;
    logic      udf;
  } lane_res_t;

  // The arithmetic is two bits wider than the word. The sum of count and incr
  // cannot carry out, and a negative result shows up in the top bit.
  function automatic lane_res_t lane_next(
    input cnt_word_t count,
    input logic      load,
    input cnt_word_t load_value,
    input cnt_word_t incr,
    input cnt_word_t decr,
    input cnt_word_t cmax,
    input logic      saturate
  );
    logic signed [CNT_MAXW+1:0] nxt;
    logic signed [CNT_MAXW+1:0] lim;
    logic signed [CNT_MAXW+1:0] modv;
    lane_res_t                  res;
    lim       = $signed({2'b00, cmax});
    modv      = lim + $signed({{(CNT_MAXW+1){1'b0}}, 1'b1});
    res.count = count;
    res.ovf   = 1'b0;
    res.udf   = 1'b0;
    if (load) begin
      nxt = $signed({2'b00, load_value});
      if (nxt > lim) begin
        res.ovf   = 1'b1;
        res.count = saturate ? cmax : cnt_word_t'(nxt % modv);
      end else begin
        res.count = load_value;
      end
    end else begin
      nxt = $signed({2'b00, count}) + $signed({2'b00, incr}) - $signed({2'b00, decr});
      if (nxt > lim) begin
        res.ovf   = 1'b1;
        res.count = saturate ? cmax : cnt_word_t'(nxt - modv);
      end else if (nxt[CNT_MAXW+1]) begin
        res.udf   = 1'b1;
        res.count = saturate ? '0 : cnt_word_t'(nxt + modv);
      end else begin
        res.count = cnt_word_t'(nxt);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_axi_counter_lane.sv
// rtl/mem_axi_counter_lane.sv - one up/down counter lane with registered flags and sticky errors
//
// Purpose: a single counter lane. It holds the count register, the zero/max
// flags derived from the next value, and the sticky overflow/underflow flags.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clken_i        enable; when low, count and zero/max flags hold
//   load_i         load strobe, takes priority over incr/decr
//   load_value_i   value to load (clamped or wrapped when above C_MAX)
//   incr_amt_i     increment amount this cycle
//   decr_amt_i     decrement amount this cycle
//   err_clr_i      clears the sticky error flags, honoured even when clken_i is low
//   count_o        registered count
//   is_zero_o      registered, count == 0
//   is_max_o       registered, count == C_MAX
//   err_ovf_o      sticky overflow flag
//   err_udf_o      sticky underflow flag

module mem_axi_counter_lane #(
  parameter int unsigned         C_WIDTH      = 8,
  parameter int unsigned         C_STEP_WIDTH = 3,
  parameter logic [C_WIDTH-1:0]  C_MAX        = {C_WIDTH{1'b1}},
  parameter logic [C_WIDTH-1:0]  C_INIT       = '0,
  parameter bit                  C_SATURATE   = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clken_i,
  input  logic                    load_i,
  input  logic [C_WIDTH-1:0]      load_value_i,
  input  logic [C_STEP_WIDTH-1:0] incr_amt_i,
  input  logic [C_STEP_WIDTH-1:0] decr_amt_i,
  input  logic                    err_clr_i,
  output logic [C_WIDTH-1:0]      count_o,
  output logic                    is_zero_o,
  output logic                    is_max_o,
  output logic                    err_ovf_o,
  output logic                    err_udf_o
);
  import mem_axi_counter_pkg::*;

  lane_res_t          res;
  logic [C_WIDTH-1:0] count_q, count_d;
  logic               zero_q, zero_d;
  logic               max_q, max_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               unused_res_hi;

  // Only the low C_WIDTH bits of the shared-width result are meaningful.
  assign unused_res_hi = ^(res.count >> C_WIDTH);

  always_comb begin
    res = lane_next(CNT_MAXW'(count_q), load_i, CNT_MAXW'(load_value_i),
                    CNT_MAXW'(incr_amt_i), CNT_MAXW'(decr_amt_i),
                    CNT_MAXW'(C_MAX), C_SATURATE);
    count_d = count_q;
    zero_d  = zero_q;
    max_d   = max_q;
    if (clken_i) begin
      count_d = C_WIDTH'(res.count);
      // Flags come from the next value so they are never a cycle stale.
      zero_d  = (count_d == '0);
      max_d   = (count_d == C_MAX);
    end
    // A new error outranks a clear in the same cycle.
    ovf_d = (ovf_q & ~err_clr_i) | (clken_i & res.ovf);
    udf_d = (udf_q & ~err_clr_i) | (clken_i & res.udf);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= C_INIT;
      zero_q  <= (C_INIT == '0);
      max_q   <= (C_INIT == C_MAX);
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count_o   = count_q;
  assign is_zero_o = zero_q;
  assign is_max_o  = max_q;
  assign err_ovf_o = ovf_q;
  assign err_udf_o = udf_q;

endmodule

// File: rtl/mem_axi_control_counter_bank.sv
// rtl/mem_axi_control_counter_bank.sv - bank of independent AXI bookkeeping counters
//
// Purpose: C_CHANNELS independent up/down counters that track credits,
// beats and per-ID pending counts for one AXI master. All buses are packed.
// Lane i occupies [i*C_WIDTH +: C_WIDTH] or [i*C_STEP_WIDTH +: C_STEP_WIDTH].
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clken        global enable (hold when low)
//   load         per-lane load strobe
//   load_value   packed load values
//   incr_amt     packed increment amounts (0 = none)
//   decr_amt     packed decrement amounts (0 = none)
//   err_clr      per-lane clear of sticky error flags
//   count        packed registered counts
//   is_zero      per-lane registered count == 0
//   is_max       per-lane registered count == C_MAX
//   err_ovf      per-lane sticky overflow
//   err_udf      per-lane sticky underflow

module mem_axi_control_counter_bank
  import mem_axi_counter_pkg::*;
#(
  parameter int unsigned        C_CHANNELS   = 4,
  parameter int unsigned        C_WIDTH      = 8,
  parameter int unsigned        C_STEP_WIDTH = 3,
  parameter logic [C_WIDTH-1:0] C_MAX        = {C_WIDTH{1'b1}},
  parameter logic [C_WIDTH-1:0] C_INIT       = '0,
  parameter bit                 C_SATURATE   = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clken,
  input  logic [C_CHANNELS-1:0]              load,
  input  logic [C_CHANNELS*C_WIDTH-1:0]      load_value,
  input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] incr_amt,
  input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] decr_amt,
  input  logic [C_CHANNELS-1:0]              err_clr,
  output logic [C_CHANNELS*C_WIDTH-1:0]      count,
  output logic [C_CHANNELS-1:0]              is_zero,
  output logic [C_CHANNELS-1:0]              is_max,
  output logic [C_CHANNELS-1:0]              err_ovf,
  output logic [C_CHANNELS-1:0]              err_udf
);

  for (genvar i = 0; i < C_CHANNELS; i++) begin : g_lane
    mem_axi_counter_lane #(
      .C_WIDTH      (C_WIDTH),
      .C_STEP_WIDTH (C_STEP_WIDTH),
      .C_MAX        (C_MAX),
      .C_INIT       (C_INIT),
      .C_SATURATE   (C_SATURATE)
    ) u_lane (
      .clk_i        (clk),
      .rst_i        (rst),
      .clken_i      (clken),
      .load_i       (load[i]),
      .load_value_i (load_value[i*C_WIDTH +: C_WIDTH]),
      .incr_amt_i   (incr_amt[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
      .decr_amt_i   (decr_amt[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
      .err_clr_i    (err_clr[i]),
      .count_o      (count[i*C_WIDTH +: C_WIDTH]),
      .is_zero_o    (is_zero[i]),
      .is_max_o     (is_max[i]),
      .err_ovf_o    (err_ovf[i]),
      .err_udf_o    (err_udf[i])
    );
  end

endmodule

// File: tb/tb_mem_axi_control_counter_bank.sv
// tb/tb_mem_axi_control_counter_bank.sv - self-checking bench for the AXI counter bank

module tb_mem_axi_control_counter_bank;

  localparam int N = 2;
  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clken = 1'b0;
  logic [N-1:0] load = '0;
  logic [N-1:0] err_clr = '0;
  logic [7:0]   load_value = '0;
  logic [3:0]   incr_amt = '0;
  logic [3:0]   decr_amt = '0;

  logic [7:0]   count_s, count_w;
  logic [N-1:0] zero_s, max_s, ovf_s, udf_s;
  logic [N-1:0] zero_w, max_w, ovf_w, udf_w;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] s;
    logic [15:0] w;
  } exp_t;

  exp_t sb_q[$];

  // Reference state: index 0 = saturating DUT, 1 = wrapping DUT.
  int m_cnt[2][2];
  bit m_ovf[2][2];
  bit m_udf[2][2];

  always #5 clk = ~clk;

  mem_axi_control_counter_bank #(
    .C_CHANNELS(N), .C_WIDTH(W), .C_STEP_WIDTH(S),
    .C_MAX(4'd12), .C_INIT(4'd0), .C_SATURATE(1'b1)
  ) dut_sat (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .load_value(load_value),
    .incr_amt(incr_amt), .decr_amt(decr_amt), .err_clr(err_clr),
    .count(count_s), .is_zero(zero_s), .is_max(max_s), .err_ovf(ovf_s), .err_udf(udf_s)
  );

  mem_axi_control_counter_bank #(
    .C_CHANNELS(N), .C_WIDTH(W), .C_STEP_WIDTH(S),
    .C_MAX(4'd12), .C_INIT(4'd0), .C_SATURATE(1'b0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .load_value(load_value),
    .incr_amt(incr_amt), .decr_amt(decr_amt), .err_clr(err_clr),
    .count(count_w), .is_zero(zero_w), .is_max(max_w), .err_ovf(ovf_w), .err_udf(udf_w)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 2; l++) begin
        m_cnt[d][l] = 0;
        m_ovf[d][l] = 1'b0;
        m_udf[d][l] = 1'b0;
      end
    end
  endtask

  // Advance the model for the current inputs, queue the expectation, clock,
  // then drain the scoreboard against both DUTs.
  task automatic step(input string tag);
    exp_t        e;
    logic [15:0] pk [2];
    for (int d = 0; d < 2; d++) begin
      logic [7:0] c_b;
      logic [1:0] z_b, mx_b, o_b, u_b;
      for (int l = 0; l < 2; l++) begin
        int c, nx, lv, iv, dv;
        bit o, u;
        c  = m_cnt[d][l];
        o  = 1'b0;
        u  = 1'b0;
        lv = int'(load_value[l*4 +: 4]);
        iv = int'(incr_amt[l*2 +: 2]);
        dv = int'(decr_amt[l*2 +: 2]);
        if (clken) begin
          if (load[l]) begin
            if (lv > 12) begin
              o = 1'b1;
              c = (d == 0) ? 12 : lv % 13;
            end else begin
              c = lv;
            end
          end else begin
            nx = c + iv - dv;
            if (nx > 12) begin
              o = 1'b1;
              c = (d == 0) ? 12 : nx - 13;
            end else if (nx < 0) begin
              u = 1'b1;
              c = (d == 0) ? 0 : nx + 13;
            end else begin
              c = nx;
            end
          end
        end
        m_ovf[d][l] = (m_ovf[d][l] && !err_clr[l]) || o;
        m_udf[d][l] = (m_udf[d][l] && !err_clr[l]) || u;
        m_cnt[d][l] = c;
        c_b[l*4 +: 4] = 4'(c);
        z_b[l]  = (c == 0);
        mx_b[l] = (c == 12);
        o_b[l]  = m_ovf[d][l];
        u_b[l]  = m_udf[d][l];
      end
      pk[d] = {c_b, z_b, mx_b, o_b, u_b};
    end
    e.s = pk[0];
    e.w = pk[1];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({count_s, zero_s, max_s, ovf_s, udf_s} !== e.s) begin
      errors++;
      $display("FAIL %s sat_state act=%h exp=%h", tag, {count_s, zero_s, max_s, ovf_s, udf_s}, e.s);
    end
    checks++;
    if ({count_w, zero_w, max_w, ovf_w, udf_w} !== e.w) begin
      errors++;
      $display("FAIL %s wrap_state act=%h exp=%h", tag, {count_w, zero_w, max_w, ovf_w, udf_w}, e.w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clken = 1'b0; load = '0; err_clr = '0;
    load_value = '0; incr_amt = 4'b0011; decr_amt = '0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (count_s !== 8'h00 || count_w !== 8'h00) begin
      errors++; $display("FAIL reset_count act=%h/%h exp=00/00", count_s, count_w);
    end
    checks++;
    if (zero_s !== 2'b11 || max_s !== 2'b00) begin
      errors++; $display("FAIL reset_flags zero=%b max=%b exp zero=11 max=00", zero_s, max_s);
    end
    checks++;
    if ({ovf_s, udf_s, ovf_w, udf_w} !== 8'h00) begin
      errors++; $display("FAIL reset_err act=%h exp=00", {ovf_s, udf_s, ovf_w, udf_w});
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) step("hold_clken0");
    checks++;
    if (count_s !== 8'h00 || zero_s !== 2'b11) begin
      errors++; $display("FAIL hold_count act=%h zero=%b exp=00 zero=11", count_s, zero_s);
    end
    clken = 1'b1; incr_amt = '0; load = 2'b01; load_value = 8'h07;
    step("load7");
    load = '0;
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (count_s !== 8'h00 || count_w !== 8'h00 || zero_s !== 2'b11) begin
      errors++; $display("FAIL async_reset act=%h/%h zero=%b exp=00/00 zero=11", count_s, count_w, zero_s);
    end
    model_reset();
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_incr_sat();
    int exp_seq[4] = '{3, 6, 9, 12};
    clken = 1'b1; incr_amt = 4'b0011; decr_amt = '0;
    for (int k = 0; k < 4; k++) begin
      step("incr3");
      checks++;
      if (count_s[3:0] !== 4'(exp_seq[k])) begin
        errors++; $display("FAIL incr_seq act=%0d exp=%0d", count_s[3:0], exp_seq[k]);
      end
    end
    checks++;
    if (max_s[0] !== 1'b1) begin
      errors++; $display("FAIL is_max_at_12 act=%b exp=1", max_s[0]);
    end
    incr_amt = 4'b0010;
    step("incr_over");
    checks++;
    if (count_s[3:0] !== 4'd12 || ovf_s[0] !== 1'b1 || count_s[7:4] !== 4'd0) begin
      errors++; $display("FAIL sat_ovf act cnt=%0d ovf=%b lane1=%0d exp 12 1 0", count_s[3:0], ovf_s[0], count_s[7:4]);
    end
  endtask

  task automatic test_net_udf();
    err_clr = 2'b11; load = 2'b01; load_value = 8'h02; incr_amt = '0; decr_amt = '0;
    step("load2");
    err_clr = '0; load = '0; incr_amt = 4'b0001; decr_amt = 4'b0011;
    step("net_to_zero");
    checks++;
    if (count_s[3:0] !== 4'd0 || zero_s[0] !== 1'b1 || udf_s[0] !== 1'b0) begin
      errors++; $display("FAIL net_zero act cnt=%0d zero=%b udf=%b exp 0 1 0", count_s[3:0], zero_s[0], udf_s[0]);
    end
    incr_amt = '0; decr_amt = 4'b0001;
    step("udf");
    checks++;
    if (count_s[3:0] !== 4'd0 || udf_s[0] !== 1'b1) begin
      errors++; $display("FAIL sat_udf act cnt=%0d udf=%b exp 0 1", count_s[3:0], udf_s[0]);
    end
  endtask

  task automatic test_wrap();
    err_clr = 2'b11; load = 2'b01; load_value = 8'h0B; incr_amt = '0; decr_amt = '0;
    step("load11");
    err_clr = '0; load = '0; incr_amt = 4'b0011;
    step("wrap_ovf");
    checks++;
    if (count_w[3:0] !== 4'd1 || ovf_w[0] !== 1'b1 || count_s[3:0] !== 4'd12) begin
      errors++; $display("FAIL wrap_ovf act w=%0d ovf=%b s=%0d exp 1 1 12", count_w[3:0], ovf_w[0], count_s[3:0]);
    end
    err_clr = 2'b11; load = 2'b01; load_value = 8'h01; incr_amt = '0;
    step("load1");
    err_clr = '0; load = '0; decr_amt = 4'b0010;
    step("wrap_udf");
    checks++;
    if (count_w[3:0] !== 4'd12 || udf_w[0] !== 1'b1 || count_s[3:0] !== 4'd0 || udf_s[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_udf act w=%0d udf=%b s=%0d exp 12 1 0", count_w[3:0], udf_w[0], count_s[3:0]);
    end
    decr_amt = '0;
  endtask

  task automatic test_load();
    err_clr = 2'b11; load = '0;
    step("clr");
    err_clr = '0; load = 2'b01; load_value = 8'h05; incr_amt = 4'b0011;
    step("load5_incr");
    checks++;
    if (count_s[3:0] !== 4'd5 || ovf_s[0] !== 1'b0) begin
      errors++; $display("FAIL load5 act cnt=%0d ovf=%b exp 5 0", count_s[3:0], ovf_s[0]);
    end
    load_value = 8'h0E;
    step("load14");
    checks++;
    if (count_s[3:0] !== 4'd12 || ovf_s[0] !== 1'b1 || count_w[3:0] !== 4'd1 || ovf_w[0] !== 1'b1) begin
      errors++; $display("FAIL load14 act s=%0d/%b w=%0d/%b exp 12/1 1/1", count_s[3:0], ovf_s[0], count_w[3:0], ovf_w[0]);
    end
    load = '0; incr_amt = '0;
  endtask

  task automatic test_err_clr();
    clken = 1'b0; err_clr = 2'b11;
    step("clr_clken0");
    checks++;
    if ({ovf_s, udf_s, ovf_w, udf_w} !== 8'h00) begin
      errors++; $display("FAIL clr_clken0 act=%h exp=00", {ovf_s, udf_s, ovf_w, udf_w});
    end
    clken = 1'b1; err_clr = '0; load = 2'b01; load_value = 8'h0C;
    step("load12");
    load = '0; incr_amt = 4'b0001; err_clr = 2'b01;
    step("clr_vs_set");
    checks++;
    if (ovf_s[0] !== 1'b1 || count_s[3:0] !== 4'd12) begin
      errors++; $display("FAIL set_wins act ovf=%b cnt=%0d exp 1 12", ovf_s[0], count_s[3:0]);
    end
    err_clr = 2'b11; load = 2'b01; load_value = 8'h04; incr_amt = '0;
    step("load4");
    err_clr = '0; load = '0; incr_amt = 4'b0010; decr_amt = 4'b0010;
    step("equal_mid");
    checks++;
    if (count_s[3:0] !== 4'd4 || count_w[3:0] !== 4'd4 || {ovf_s, udf_s, ovf_w, udf_w} !== 8'h00) begin
      errors++; $display("FAIL equal_mid act s=%0d w=%0d err=%h exp 4 4 00", count_s[3:0], count_w[3:0], {ovf_s, udf_s, ovf_w, udf_w});
    end
    load = 2'b01; load_value = 8'h0C; incr_amt = '0; decr_amt = '0;
    step("load12b");
    load = '0; incr_amt = 4'b0011; decr_amt = 4'b0011;
    step("equal_max");
    checks++;
    if (count_s[3:0] !== 4'd12 || ovf_s[0] !== 1'b0 || max_s[0] !== 1'b1) begin
      errors++; $display("FAIL equal_max act cnt=%0d ovf=%b max=%b exp 12 0 1", count_s[3:0], ovf_s[0], max_s[0]);
    end
    incr_amt = '0; decr_amt = '0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      clken      = ($urandom_range(0, 7) != 0);
      load       = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      load_value = 8'($urandom);
      incr_amt   = 4'($urandom);
      decr_amt   = 4'($urandom);
      err_clr    = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      step("random");
    end
    clken = 1'b1; load = '0; incr_amt = '0; decr_amt = '0; err_clr = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_incr_sat();
    test_net_udf();
    test_wrap();
    test_load();
    test_err_clr();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
